// File: rtl/ecs_scheduler_if.sv
// Scheduler bus: header/component chunk sources in, grants and merged chunk out.
// The master side is the scheduler; the slave side is the sources and the packer.
interface ecs_scheduler_if #(parameter int XW = 8);
  logic                 start;
  logic [XW-1:0]        h_mcu;
  logic                 hdr_req;
  logic                 hdr_done;
  logic [5:0]           hdr_elen;
  logic [31:0]          hdr_edata;
  logic [2:0][5:0]      ce_elen;
  logic [2:0][31:0]     ce_edata;
  logic [2:0]           ce_done;
  logic [2:0]           ereq;
  logic [XW-1:0]        e_x_mcu;
  logic [5:0]           elen;
  logic [31:0]          edata;
  logic                 busy;
  logic                 row_done;
  logic                 err;

  modport master (
    input  start, h_mcu, hdr_req, hdr_done, hdr_elen, hdr_edata,
           ce_elen, ce_edata, ce_done,
    output ereq, e_x_mcu, elen, edata, busy, row_done, err
  );

  modport slave (
    output start, h_mcu, hdr_req, hdr_done, hdr_elen, hdr_edata,
           ce_elen, ce_edata, ce_done,
    input  ereq, e_x_mcu, elen, edata, busy, row_done, err
  );
endinterface

// File: rtl/ecs_scheduler.sv
// Grants header or Y/Cb/Cr encoders in turn per MCU and merges their chunks; output is 1 cycle late.
// No backpressure: sources advance on their own done; a watchdog forces progress on a stuck component.
module ecs_scheduler #(
  parameter int XW      = 8,
  parameter int GAP_CYC = 8,
  parameter int WDOG    = 63
) (
  input  logic               clk,
  input  logic               rst_n,
  ecs_scheduler_if.master    bus
);

  typedef enum logic [2:0] {IDLE, HDR, Y, CB, CR, GAP} state_t;

  localparam logic [15:0] WD_LAST  = 16'(WDOG - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  state_t        state, state_nxt;
  logic [XW-1:0] x_max, x_max_nxt;
  logic [XW-1:0] x_cur, x_cur_nxt;
  logic [XW-1:0] x_inc;
  logic [15:0]   cnt, cnt_nxt;
  logic          row_done_q, row_done_nxt;
  logic          err_q, err_nxt;
  logic [5:0]    elen_q, sel_elen;
  logic [31:0]   edata_q, sel_data;
  logic [2:0]    grant;
  logic [1:0]    idx;
  logic          timeout;

  assign x_inc   = x_cur + 1'b1;
  assign timeout = (cnt == WD_LAST);

  always_comb begin
    idx = 2'd0;
    if (state == CB) idx = 2'd1;
    else if (state == CR) idx = 2'd2;
  end

  always_comb begin
    state_nxt    = state;
    x_max_nxt    = x_max;
    x_cur_nxt    = x_cur;
    cnt_nxt      = cnt + 16'd1;
    row_done_nxt = 1'b0;
    err_nxt      = err_q;
    grant        = 3'b000;
    sel_elen     = 6'd0;
    sel_data     = 32'd0;

    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        if (bus.hdr_req) begin
          state_nxt = HDR;
        end else if (bus.start) begin
          if (bus.h_mcu == '0) begin
            row_done_nxt = 1'b1;
          end else begin
            x_max_nxt = bus.h_mcu;
            x_cur_nxt = '0;
            state_nxt = Y;
          end
        end
      end
      HDR: begin
        cnt_nxt  = 16'd0;
        sel_elen = bus.hdr_elen;
        sel_data = bus.hdr_edata;
        if (bus.hdr_done) state_nxt = IDLE;
      end
      Y, CB, CR: begin
        grant[idx] = 1'b1;
        sel_elen   = bus.ce_elen[idx];
        sel_data   = bus.ce_edata[idx];
        // A stuck encoder is treated as done so the row still completes.
        if (bus.ce_done[idx] || timeout) begin
          cnt_nxt = 16'd0;
          if (!bus.ce_done[idx]) err_nxt = 1'b1;
          case (state)
            Y:       state_nxt = CB;
            CB:      state_nxt = CR;
            default: begin
              if (x_inc == x_max) begin
                state_nxt = GAP;
              end else begin
                x_cur_nxt = x_inc;
                state_nxt = Y;
              end
            end
          endcase
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt      = 16'd0;
          row_done_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.start && (state != IDLE || bus.hdr_req)) err_nxt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!grant[i] && (bus.ce_elen[i] != 6'd0 || bus.ce_done[i])) err_nxt = 1'b1;
    end
    if (state != HDR && (bus.hdr_elen != 6'd0 || bus.hdr_done)) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_max      <= '0;
      x_cur      <= '0;
      cnt        <= 16'd0;
      row_done_q <= 1'b0;
      err_q      <= 1'b0;
      elen_q     <= 6'd0;
      edata_q    <= 32'd0;
    end else begin
      state      <= state_nxt;
      x_max      <= x_max_nxt;
      x_cur      <= x_cur_nxt;
      cnt        <= cnt_nxt;
      row_done_q <= row_done_nxt;
      err_q      <= err_nxt;
      elen_q     <= sel_elen;
      edata_q    <= (sel_elen == 6'd0) ? 32'd0 : sel_data;
    end
  end

  assign bus.ereq     = grant;
  assign bus.e_x_mcu  = x_cur;
  assign bus.elen     = elen_q;
  assign bus.edata    = edata_q;
  assign bus.busy     = (state == Y) || (state == CB) || (state == CR) || (state == GAP);
  assign bus.row_done = row_done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ecs_scheduler.sv
// Directed bench: stimulus queues expected grants, chunks and row ends; a negedge monitor checks them.
module tb_ecs_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ecs_scheduler_if #(.XW(8)) bus ();

  ecs_scheduler #(.XW(8), .GAP_CYC(8), .WDOG(63)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed { logic [2:0] ereq; logic [7:0] x; } gexp_t;
  typedef struct packed { logic [5:0] l; logic [31:0] d; } dexp_t;

  gexp_t grant_q[$];
  dexp_t data_q[$];
  int    row_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] prev_ereq = 3'b000;
  int gap_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    gexp_t g;
    dexp_t d;
    int    r;
    if (rst_n) begin
      if (bus.ereq != 3'b000 && bus.ereq != prev_ereq) begin
        if (grant_q.size() == 0) begin
          check("grant_unexpected", {bus.ereq, bus.e_x_mcu}, 64'd0);
        end else begin
          g = grant_q.pop_front();
          check("grant", {bus.ereq, bus.e_x_mcu}, {g.ereq, g.x});
        end
      end
      if (bus.elen != 6'd0) begin
        if (data_q.size() == 0) begin
          check("data_unexpected", {bus.elen, bus.edata}, 64'd0);
        end else begin
          d = data_q.pop_front();
          check("data", {bus.elen, bus.edata}, {d.l, d.d});
        end
      end else begin
        check("edata_zero", bus.edata, 64'd0);
      end
      if (bus.row_done) begin
        if (row_q.size() == 0) begin
          check("row_done_unexpected", 64'd1, 64'd0);
        end else begin
          r = row_q.pop_front();
          check("gap_len", gap_run, r);
        end
        gap_run = 0;
      end else if (bus.busy && bus.ereq == 3'b000) begin
        gap_run++;
      end else begin
        gap_run = 0;
      end
    end
    prev_ereq = bus.ereq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start     = 1'b0;
    bus.h_mcu     = 8'd0;
    bus.hdr_req   = 1'b0;
    bus.hdr_done  = 1'b0;
    bus.hdr_elen  = 6'd0;
    bus.hdr_edata = 32'd0;
    bus.ce_elen   = '0;
    bus.ce_edata  = '0;
    bus.ce_done   = 3'b000;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_grant(input logic [2:0] e, input logic [7:0] x);
    gexp_t g;
    g.ereq = e;
    g.x    = x;
    grant_q.push_back(g);
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (!bus.ereq[i] && n < 200) begin
      tick();
      n++;
    end
    check("wait_grant", {63'd0, bus.ereq[i]}, 64'd1);
  endtask

  // Grant cycle 1 carries an optional chunk, cycle 2 junk data with elen=0, done in cycle 4.
  task automatic serve(input int i, input bit with_data, input logic [5:0] l, input logic [31:0] dv);
    dexp_t d;
    wait_grant(i);
    if (with_data) begin
      bus.ce_elen[i]  = l;
      bus.ce_edata[i] = dv;
      d.l = l;
      d.d = dv;
      data_q.push_back(d);
    end
    tick();
    bus.ce_elen[i]  = 6'd0;
    bus.ce_edata[i] = 32'hDEAD_BEEF;
    tick();
    bus.ce_edata[i] = 32'd0;
    tick();
    bus.ce_done[i] = 1'b1;
    tick();
    bus.ce_done[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
    check("wait_idle", {63'd0, bus.busy}, 64'd0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    dexp_t hd;
    clear_inputs();
    #3;
    check("reset_outputs", {bus.ereq, bus.e_x_mcu, bus.elen, bus.edata,
                            bus.busy, bus.row_done, bus.err}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Two-MCU row, every component returns one chunk.
    push_grant(3'b001, 8'd0); push_grant(3'b010, 8'd0); push_grant(3'b100, 8'd0);
    push_grant(3'b001, 8'd1); push_grant(3'b010, 8'd1); push_grant(3'b100, 8'd1);
    row_q.push_back(8);
    bus.h_mcu = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_in_row", {63'd0, bus.busy}, 64'd1);
    for (int k = 0; k < 6; k++)
      serve(k % 3, 1'b1, 6'(k + 1), 32'hA000_0000 + 32'(k));
    wait_idle();
    check("err_clean_row", {63'd0, bus.err}, 64'd0);

    // Header request wins over a simultaneous start.
    do_reset();
    bus.hdr_req = 1'b1;
    bus.start   = 1'b1;
    bus.h_mcu   = 8'd1;
    tick();
    bus.hdr_req = 1'b0;
    bus.start   = 1'b0;
    check("hdr_start_err", {63'd0, bus.err}, 64'd1);
    check("hdr_no_grant", {61'd0, bus.ereq}, 64'd0);
    check("hdr_not_busy", {63'd0, bus.busy}, 64'd0);
    bus.hdr_elen  = 6'd8;
    bus.hdr_edata = 32'h0000_00FF;
    bus.hdr_done  = 1'b1;
    hd.l = 6'd8;
    hd.d = 32'h0000_00FF;
    data_q.push_back(hd);
    tick();
    bus.hdr_elen  = 6'd0;
    bus.hdr_edata = 32'd0;
    bus.hdr_done  = 1'b0;
    repeat (4) tick();
    check("hdr_back_idle", {63'd0, bus.busy}, 64'd0);

    // Zero-width row ends at once.
    do_reset();
    row_q.push_back(0);
    bus.h_mcu = 8'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero_row_done", {63'd0, bus.row_done}, 64'd1);
    check("zero_row_busy", {63'd0, bus.busy}, 64'd0);
    tick();
    check("zero_row_ereq", {61'd0, bus.ereq}, 64'd0);
    check("zero_row_err", {63'd0, bus.err}, 64'd0);

    // Y never finishes: watchdog after 63 grant cycles.
    do_reset();
    push_grant(3'b001, 8'd0); push_grant(3'b010, 8'd0); push_grant(3'b100, 8'd0);
    row_q.push_back(8);
    bus.h_mcu = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (62) tick();
    check("wdog_before", {60'd0, bus.err, bus.ereq}, {60'd0, 1'b0, 3'b001});
    tick();
    check("wdog_after", {60'd0, bus.err, bus.ereq}, {60'd0, 1'b1, 3'b010});
    serve(1, 1'b0, 6'd0, 32'd0);
    serve(2, 1'b0, 6'd0, 32'd0);
    wait_idle();

    // Cb talks while Y holds the grant.
    do_reset();
    push_grant(3'b001, 8'd0); push_grant(3'b010, 8'd0); push_grant(3'b100, 8'd0);
    row_q.push_back(8);
    bus.h_mcu = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ce_elen[1]  = 6'd5;
    bus.ce_edata[1] = 32'h5555_0005;
    tick();
    bus.ce_elen[1]  = 6'd0;
    bus.ce_edata[1] = 32'd0;
    check("intruder_elen", {58'd0, bus.elen}, 64'd0);
    check("intruder_err", {63'd0, bus.err}, 64'd1);
    serve(0, 1'b0, 6'd0, 32'd0);
    serve(1, 1'b0, 6'd0, 32'd0);
    serve(2, 1'b0, 6'd0, 32'd0);
    wait_idle();

    // Reset in the middle of Cr drops the row.
    do_reset();
    push_grant(3'b001, 8'd0); push_grant(3'b010, 8'd0); push_grant(3'b100, 8'd0);
    bus.h_mcu = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    serve(0, 1'b0, 6'd0, 32'd0);
    serve(1, 1'b0, 6'd0, 32'd0);
    wait_grant(2);
    bus.ce_elen[2]  = 6'd7;
    bus.ce_edata[2] = 32'h1234_5678;
    hd.l = 6'd7;
    hd.d = 32'h1234_5678;
    data_q.push_back(hd);
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrow_reset_outs", {bus.ereq, bus.e_x_mcu, bus.elen, bus.edata,
                                bus.busy, bus.row_done, bus.err}, 64'd0);
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("after_reset_ereq", {60'd0, bus.busy, bus.ereq}, 64'd0);

    tick();
    check("grant_q_empty", grant_q.size(), 64'd0);
    check("data_q_empty", data_q.size(), 64'd0);
    check("row_q_empty", row_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ecs_scheduler.md
ECS_SCHEDULER -- requirements
Module: ecs_scheduler

Interface
REQ-001 SHALL have parameter XW, default 8, MCU column index width.
REQ-002 SHALL have parameter GAP_CYC, default 8, idle cycles after the last MCU of a row.
REQ-003 SHALL have parameter WDOG, default 63, maximum grant cycles per component before a timeout.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse: MCU row ready for encoding.
REQ-007 SHALL have port h_mcu  input  XW  MCUs per row, sampled on accepted start.
REQ-008 SHALL have port hdr_req  input  1  header/footer source has pending bytes.
REQ-009 SHALL have port hdr_done  input  1  header/footer source finished; held with last hdr_elen.
REQ-010 SHALL have port hdr_elen/hdr_edata  input  6/32  header/footer bit chunk.
REQ-011 SHALL have port ce_elen/ce_edata  input  3x6/3x32  component chunks, index 0=Y, 1=Cb, 2=Cr.
REQ-012 SHALL have port ce_done  input  3  component finished its current MCU block.
REQ-013 SHALL have port ereq  output  3  one-hot-or-zero grant to component encoders.
REQ-014 SHALL have port e_x_mcu  output  XW  MCU column currently being encoded.
REQ-015 SHALL have port elen/edata  output  6/32  merged chunk to bitstream packer.
REQ-016 SHALL have ports busy, row_done, err  output  1 each  row in progress; one-cycle end-of-row pulse; sticky protocol error.

Function
REQ-017 SHALL implement states IDLE, HDR, Y, CB, CR, GAP.
REQ-018 SHALL, in IDLE with hdr_req=1, enter HDR; HDR exits to IDLE on the cycle after hdr_done=1.
REQ-019 SHALL, in IDLE with hdr_req=0 and start=1, latch h_mcu, clear e_x_mcu, and enter Y; if latched h_mcu=0, instead pulse row_done next cycle and stay IDLE.
REQ-020 SHALL give hdr_req priority over a simultaneous start; a start arriving while not in IDLE SHALL be dropped and SHALL set err.
REQ-021 SHALL assert ereq[0], ereq[1] and ereq[2] in Y, CB and CR respectively; ereq SHALL be 0 in every other state.
REQ-022 SHALL advance Y->CB->CR on ce_done of the granted index; CR with ce_done[2] SHALL increment e_x_mcu and return to Y, or enter GAP when e_x_mcu+1 == latched h_mcu.
REQ-023 SHALL hold GAP for exactly GAP_CYC cycles with ereq=0, then pulse row_done for one cycle and enter IDLE.
REQ-024 SHALL keep busy=1 in Y, CB, CR and GAP, and busy=0 otherwise.
REQ-025 SHALL count grant cycles per component state; reaching WDOG without ce_done SHALL set err and force that component's done.
REQ-026 SHALL register the output with 1-cycle latency: elen/edata equal the granted source's elen/edata from the previous cycle (HDR->hdr_*, Y/CB/CR->ce_*[i]); otherwise elen=0 and edata=0.
REQ-027 SHALL force edata=0 whenever the selected elen=0.
REQ-028 SHALL set err when a non-granted source presents nonzero elen or asserts done; that data SHALL be discarded.
REQ-029 SHALL clear err only by reset.
REQ-030 SHALL not wrap e_x_mcu: its maximum value is h_mcu-1.

Reset
REQ-031 SHALL, while rst_n=0 (asynchronous), force state IDLE and ereq=0, e_x_mcu=0, elen=0, edata=0, busy=0, row_done=0, err=0, with all counters cleared.
REQ-032 SHALL, on reset mid-row, drop the row and SHALL require a new start after release.

Verification
REQ-033 SHALL test: h_mcu=2, start, each encoder returns one chunk then done after 3 cycles -> ereq sequence 001,010,100,001,010,100; e_x_mcu 0,0,0,1,1,1; 8 GAP cycles; one row_done.
REQ-034 SHALL test: hdr_req and start in the same cycle -> HDR granted, hdr chunk elen=8/edata=0xFF appears 1 cycle later, start dropped, err=1.
REQ-035 SHALL test: h_mcu=0 with start -> row_done the next cycle, ereq stays 000, busy stays 0.
REQ-036 SHALL test: Y granted and never done -> err=1 after 63 cycles, then advance to CB.
REQ-037 SHALL test: Cb presents elen=5 while Y is granted -> output elen=0, err=1.
REQ-038 SHALL test: rst_n low during CR -> all outputs 0 immediately; after release no ereq until the next start.
